// File: rtl/serial_scheduler.sv
// Round-robin byte scheduler feeding a serializer: sends COM training symbols after
// reset/retrain, then grants one requester byte per clk_4f cycle.
module serial_scheduler #(
    parameter int         TRAIN_CYCLES = 8,
    parameter logic [7:0] COM          = 8'hBC
) (
    input  logic        clk_4f,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [7:0]  data_in0,
    input  logic [7:0]  data_in1,
    input  logic [7:0]  data_in2,
    input  logic [7:0]  data_in3,
    input  logic        retrain,
    output logic [3:0]  pop,
    output logic [7:0]  data_out,
    output logic        valid_out,
    output logic [1:0]  grant_id,
    output logic        trained,
    output logic [15:0] bytes_sent
);

    typedef enum logic {TRAIN, ACTIVE} state_t;

    localparam logic [7:0] TRAIN_LOAD = 8'(TRAIN_CYCLES);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  rr_q, rr_d;
    logic [7:0]  dout_q, dout_d;
    logic        vld_q, vld_d;
    logic [1:0]  gid_q, gid_d;
    logic [15:0] bs_q, bs_d;

    logic [7:0]  din [4];
    logic        gnt_found;
    logic [1:0]  gnt_idx;
    logic [1:0]  idx;
    logic [3:0]  pop_raw;

    assign din[0] = data_in0;
    assign din[1] = data_in1;
    assign din[2] = data_in2;
    assign din[3] = data_in3;

    // First requester at or after rr_q; 2-bit index wraps modulo 4 naturally.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = rr_q;
        idx       = rr_q;
        for (int k = 0; k < 4; k++) begin
            idx = rr_q + 2'(k);
            if (!gnt_found && req[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        dout_d  = COM;
        vld_d   = 1'b0;
        gid_d   = gid_q;
        bs_d    = bs_q;
        pop_raw = 4'b0000;
        case (state_q)
            TRAIN: begin
                if (retrain) begin
                    cnt_d = TRAIN_LOAD;
                end else if (cnt_q <= 8'd1) begin
                    state_d = ACTIVE;
                    cnt_d   = TRAIN_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ACTIVE: begin
                if (retrain) begin
                    state_d = TRAIN;
                    cnt_d   = TRAIN_LOAD;
                end else if (gnt_found) begin
                    pop_raw = 4'b0001 << gnt_idx;
                    dout_d  = din[gnt_idx];
                    vld_d   = 1'b1;
                    gid_d   = gnt_idx;
                    rr_d    = gnt_idx + 2'd1;
                    bs_d    = bs_q + 16'd1;
                end
            end
            default: state_d = TRAIN;
        endcase
    end

    // A strobe during reset would drain a FIFO byte that is never sent.
    assign pop = reset ? 4'b0000 : pop_raw;

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            state_q <= TRAIN;
            cnt_q   <= TRAIN_LOAD;
            rr_q    <= 2'd0;
            dout_q  <= COM;
            vld_q   <= 1'b0;
            gid_q   <= 2'd0;
            bs_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            gid_q   <= gid_d;
            bs_q    <= bs_d;
        end
    end

    assign data_out   = dout_q;
    assign valid_out  = vld_q;
    assign grant_id   = gid_q;
    assign trained    = (state_q == ACTIVE);
    assign bytes_sent = bs_q;

endmodule

// File: tb/tb_serial_scheduler.sv
// Bench for serial_scheduler: directed vector table, random run against a
// queue-free behavioural model, counter wrap and asynchronous reset checks.
module tb_serial_scheduler;

    localparam int TC = 8;

    logic        clk_4f = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [7:0]  d0, d1, d2, d3;
    logic        retrain;
    logic [3:0]  pop;
    logic [7:0]  data_out;
    logic        valid_out;
    logic [1:0]  grant_id;
    logic        trained;
    logic [15:0] bytes_sent;

    serial_scheduler #(.TRAIN_CYCLES(TC), .COM(8'hBC)) dut (
        .clk_4f(clk_4f), .reset(reset), .req(req),
        .data_in0(d0), .data_in1(d1), .data_in2(d2), .data_in3(d3),
        .retrain(retrain), .pop(pop), .data_out(data_out), .valid_out(valid_out),
        .grant_id(grant_id), .trained(trained), .bytes_sent(bytes_sent)
    );

    always #5 clk_4f = ~clk_4f;

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: link trained flag, training cycles left, next-search pointer.
    bit          m_tr;
    int          m_left;
    int          m_rr;
    logic [7:0]  m_dout;
    bit          m_vld;
    int          m_gid;
    logic [15:0] m_bs;

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] exp_pop();
        if (!m_tr || retrain || req == 4'b0000) return 4'b0000;
        return 4'(1 << pick(req, m_rr));
    endfunction

    task automatic m_reset();
        m_tr = 0; m_left = TC; m_rr = 0; m_dout = 8'hBC; m_vld = 0; m_gid = 0; m_bs = 16'd0;
    endtask

    task automatic m_edge();
        logic [7:0] din [4];
        int g;
        din = '{d0, d1, d2, d3};
        m_dout = 8'hBC;
        m_vld  = 0;
        if (!m_tr) begin
            if (retrain)          m_left = TC;
            else if (m_left == 1) m_tr = 1;
            else                  m_left--;
        end else if (retrain) begin
            m_tr = 0;
            m_left = TC;
        end else if (req != 4'b0000) begin
            g = pick(req, m_rr);
            m_dout = din[g];
            m_vld = 1;
            m_gid = g;
            m_rr = (g + 1) % 4;
            m_bs = m_bs + 16'd1;
        end
    endtask

    task automatic check_model();
        chk("data_out",   32'(data_out),   32'(m_dout));
        chk("valid_out",  32'(valid_out),  32'(m_vld));
        chk("grant_id",   32'(grant_id),   32'(m_gid));
        chk("trained",    32'(trained),    32'(m_tr));
        chk("bytes_sent", 32'(bytes_sent), 32'(m_bs));
    endtask

    // Entered at posedge+1 with inputs set; leaves at the next posedge+1.
    task automatic cycle();
        #3;
        chk("pop", 32'(pop), 32'(exp_pop()));
        @(posedge clk_4f);
        #1;
        m_edge();
        check_model();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_pop"},   32'(pop),        32'h0);
        chk({tag, "_dout"},  32'(data_out),   32'hBC);
        chk({tag, "_vld"},   32'(valid_out),  32'h0);
        chk({tag, "_gid"},   32'(grant_id),   32'h0);
        chk({tag, "_tr"},    32'(trained),    32'h0);
        chk({tag, "_bs"},    32'(bytes_sent), 32'h0);
    endtask

    // Asserted between edges: outputs must clear with no clock edge.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #2;
        check_reset_vals(tag);
        m_reset();
        @(posedge clk_4f);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  req;
        logic        rt;
        logic [3:0]  pop;
        logic [7:0]  dout;
        logic        vld;
        logic [1:0]  gid;
        logic        tr;
        logic [15:0] bs;
    } vec_t;

    vec_t tbl[$];

    initial begin
        reset = 1'b1; req = 4'hF; retrain = 1'b0;
        d0 = 8'h10; d1 = 8'h11; d2 = 8'h12; d3 = 8'h13;

        for (int i = 0; i < TC; i++)
            tbl.push_back('{4'hF, 1'b0, 4'b0000, 8'hBC, 1'b0, 2'd0, (i == TC - 1), 16'd0});
        tbl.push_back('{4'hF,    1'b0, 4'b0001, 8'h10, 1'b1, 2'd0, 1'b1, 16'd1});
        tbl.push_back('{4'hF,    1'b0, 4'b0010, 8'h11, 1'b1, 2'd1, 1'b1, 16'd2});
        tbl.push_back('{4'hF,    1'b0, 4'b0100, 8'h12, 1'b1, 2'd2, 1'b1, 16'd3});
        tbl.push_back('{4'hF,    1'b0, 4'b1000, 8'h13, 1'b1, 2'd3, 1'b1, 16'd4});
        tbl.push_back('{4'hF,    1'b0, 4'b0001, 8'h10, 1'b1, 2'd0, 1'b1, 16'd5});
        tbl.push_back('{4'b0010, 1'b0, 4'b0010, 8'h11, 1'b1, 2'd1, 1'b1, 16'd6});
        tbl.push_back('{4'b0011, 1'b0, 4'b0001, 8'h10, 1'b1, 2'd0, 1'b1, 16'd7});
        for (int i = 0; i < 3; i++)
            tbl.push_back('{4'b0000, 1'b0, 4'b0000, 8'hBC, 1'b0, 2'd0, 1'b1, 16'd7});
        tbl.push_back('{4'b0100, 1'b0, 4'b0100, 8'h12, 1'b1, 2'd2, 1'b1, 16'd8});
        tbl.push_back('{4'hF,    1'b1, 4'b0000, 8'hBC, 1'b0, 2'd2, 1'b0, 16'd8});
        for (int i = 0; i < TC; i++)
            tbl.push_back('{4'hF, 1'b0, 4'b0000, 8'hBC, 1'b0, 2'd2, (i == TC - 1), 16'd8});
        tbl.push_back('{4'hF,    1'b0, 4'b1000, 8'h13, 1'b1, 2'd3, 1'b1, 16'd9});

        #1;
        check_reset_vals("rst0");
        repeat (2) @(posedge clk_4f);
        #1;
        check_reset_vals("rst_hold");
        reset = 1'b0;

        foreach (tbl[i]) begin
            req = tbl[i].req;
            retrain = tbl[i].rt;
            #3;
            chk($sformatf("t%0d_pop", i), 32'(pop), 32'(tbl[i].pop));
            @(posedge clk_4f);
            #1;
            chk($sformatf("t%0d_dout", i), 32'(data_out),   32'(tbl[i].dout));
            chk($sformatf("t%0d_vld", i),  32'(valid_out),  32'(tbl[i].vld));
            chk($sformatf("t%0d_gid", i),  32'(grant_id),   32'(tbl[i].gid));
            chk($sformatf("t%0d_tr", i),   32'(trained),    32'(tbl[i].tr));
            chk($sformatf("t%0d_bs", i),   32'(bytes_sent), 32'(tbl[i].bs));
        end

        // Random traffic with occasional retrain and mid-traffic resets.
        do_reset("rst_rand");
        for (int n = 0; n < 800; n++) begin
            req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            retrain = ($urandom_range(0, 23) == 0);
            d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom); d3 = 8'($urandom);
            if (n == 400) do_reset("rst_mid");
            cycle();
        end

        // Continuous streaming until bytes_sent wraps.
        req = 4'hF; retrain = 1'b0;
        do_reset("rst_wrap");
        repeat (TC + 65535) cycle();
        chk("bs_ffff", 32'(bytes_sent), 32'hFFFF);
        cycle();
        chk("bs_wrap", 32'(bytes_sent), 32'h0);
        repeat (3) cycle();
        do_reset("rst_run");
        repeat (TC + 4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
